// File: rtl/inv_sbox_word_seq.sv
// Word-serial inverse substitution: streams one nibble per cycle through a
// shared external 4-bit inverse S-box and reassembles the result word.
module inv_sbox_word_seq #(
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    output logic [3:0]        sbox_in,
    input  logic [3:0]        sbox_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_data,
    output logic              busy
);

    localparam int NIB = WORD_W / 4;
    localparam int CW  = $clog2(NIB + 1);

    typedef enum logic [1:0] {
        IDLE,
        SUB,
        DONE
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [CW-1:0]     cnt_q;
    logic [WORD_W-1:0] work_q;
    logic [WORD_W-1:0] res_q;
    logic [WORD_W-1:0] res_d;
    logic [WORD_W-1:0] out_q;
    logic [3:0]        nib;
    logic              last;

    assign last = (cnt_q == CW'(NIB - 1));

    // Nibble select and write-back share the same counter decode.
    always_comb begin
        nib   = 4'h0;
        res_d = res_q;
        for (int i = 0; i < NIB; i++) begin
            if (cnt_q == CW'(i)) begin
                nib              = work_q[4*i +: 4];
                res_d[4*i +: 4]  = sbox_out;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        sbox_in   = 4'h0;
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) state_d = SUB;
            end
            SUB: begin
                sbox_in = nib;
                if (last) state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // out_q only changes when the full word is complete, so out_data is
    // stable everywhere except the SUB->DONE edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            work_q <= '0;
            res_q  <= '0;
            out_q  <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        work_q <= in_data;
                        cnt_q  <= '0;
                    end
                end
                SUB: begin
                    res_q <= res_d;
                    if (last) begin
                        out_q <= res_d;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_data = out_q;

endmodule

// File: tb/tb_inv_sbox_word_seq.sv
// Randomized and directed bench for inv_sbox_word_seq against a
// nibble-wise reference model (32-bit and 4-bit instances).
module tb_inv_sbox_word_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [3:0]  sbox_in;
    logic [3:0]  sbox_out;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        busy;

    logic        in_valid4;
    logic        in_ready4;
    logic [3:0]  in_data4;
    logic [3:0]  sbox_in4;
    logic [3:0]  sbox_out4;
    logic        out_valid4;
    logic        out_ready4;
    logic [3:0]  out_data4;
    logic        busy4;

    int total = 0;
    int bad   = 0;

    assign sbox_out  = 4'hF - sbox_in;
    assign sbox_out4 = 4'hF - sbox_in4;

    inv_sbox_word_seq #(.WORD_W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .sbox_in   (sbox_in),
        .sbox_out  (sbox_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    inv_sbox_word_seq #(.WORD_W(4)) dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid4),
        .in_ready  (in_ready4),
        .in_data   (in_data4),
        .sbox_in   (sbox_in4),
        .sbox_out  (sbox_out4),
        .out_valid (out_valid4),
        .out_ready (out_ready4),
        .out_data  (out_data4),
        .busy      (busy4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input logic [31:0] d);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            r[4*i +: 4] = 4'hF - d[4*i +: 4];
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Entered 1 time unit after an edge with the DUT idle.
    task automatic do_word(input logic [31:0] d, input int hold);
        in_valid  = 1'b1;
        in_data   = d;
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        in_data  = $urandom;
        for (int k = 0; k < 8; k++) begin
            check("sbox_in_seq", 32'(sbox_in), 32'(d[4*k +: 4]));
            check("no_early_valid", 32'(out_valid), 32'd0);
            check("busy_sub", 32'(busy), 32'd1);
            out_ready = 1'($urandom);
            tick();
        end
        check("valid_at_e8", 32'(out_valid), 32'd1);
        check("data_at_e8", out_data, ref_word(d));
        for (int h = 0; h < hold; h++) begin
            out_ready = 1'b0;
            in_valid  = 1'b1;
            in_data   = $urandom;
            check("no_accept_done", 32'(in_ready), 32'd0);
            tick();
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_data", out_data, ref_word(d));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("post_hs_valid", 32'(out_valid), 32'd0);
        check("post_hs_ready", 32'(in_ready), 32'd1);
        check("post_hs_hold", out_data, ref_word(d));
    endtask

    initial begin
        logic [31:0] d;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        out_ready  = 1'b0;
        in_valid4  = 1'b0;
        in_data4   = '0;
        out_ready4 = 1'b0;
        #12;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_sbox_in", 32'(sbox_in), 32'd0);
        check("rst_out_data", out_data, 32'd0);
        rst_n = 1'b1;
        tick();

        do_word(32'h0123_4567, 0);
        check("single_ref", ref_word(32'h0123_4567), 32'hFEDC_BA98);
        do_word(32'hFFFF_0000, 5);

        in_valid = 1'b1;
        in_data  = 32'h0000_0000;
        tick();
        in_data = 32'h1234_5678;
        repeat (8) tick();
        check("b2b_v1", 32'(out_valid), 32'd1);
        check("b2b_d1", out_data, 32'hFFFF_FFFF);
        in_data   = 32'hAAAA_5555;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("b2b_idle", 32'(in_ready), 32'd1);
        check("b2b_nv", 32'(out_valid), 32'd0);
        tick();
        in_valid = 1'b0;
        check("b2b_accept", 32'(busy), 32'd1);
        check("b2b_nib0", 32'(sbox_in), 32'h5);
        repeat (8) tick();
        check("b2b_v2", 32'(out_valid), 32'd1);
        check("b2b_d2", out_data, 32'h5555_AAAA);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        d        = $urandom;
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        check("mid_k3", 32'(sbox_in), 32'(d[15:12]));
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_ready", 32'(in_ready), 32'd1);
        check("arst_sbox", 32'(sbox_in), 32'd0);
        check("arst_data", out_data, 32'd0);
        #2 rst_n = 1'b1;
        tick();
        do_word(32'h1111_1111, 0);

        for (int n = 0; n < 20; n++) begin
            do_word($urandom, $urandom_range(0, 3));
        end

        in_valid4 = 1'b1;
        in_data4  = 4'h9;
        tick();
        in_valid4 = 1'b0;
        check("w4_sbox_in", 32'(sbox_in4), 32'h9);
        check("w4_no_valid", 32'(out_valid4), 32'd0);
        check("w4_busy", 32'(busy4), 32'd1);
        tick();
        check("w4_valid_e1", 32'(out_valid4), 32'd1);
        check("w4_data", 32'(out_data4), 32'h6);
        check("w4_sbox_idle", 32'(sbox_in4), 32'd0);
        out_ready4 = 1'b1;
        tick();
        out_ready4 = 1'b0;
        check("w4_ready", 32'(in_ready4), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
